// File: rtl/ahb_slave_mem.sv
// AHB-Lite memory slave: word-organised RAM with byte/half/word writes,
// a configurable number of wait states per OKAY transfer and a two-cycle
// ERROR response for illegal address phases.
//
// Handshake: an address phase is taken on a rising edge where hready=1,
// hsel=1 and htrans is NONSEQ or SEQ. While hready=0 the address-phase
// inputs are ignored and the master must hold hwdata stable. The data
// phase ends on the first rising edge with hready=1 (the completion cycle
// or ERR2). A new address phase may be presented in that same cycle.
module ahb_slave_mem #(
    parameter int MEM_WORDS   = 256,
    parameter int WAIT_STATES = 2
) (
    input  logic        hclk,
    input  logic        hreset,
    input  logic        hsel,
    input  logic [31:0] haddr,
    input  logic [1:0]  htrans,
    input  logic        hwrite,
    input  logic [2:0]  hsize,
    input  logic [2:0]  hburst,
    input  logic [31:0] hwdata,
    input  logic [3:0]  hmaster,
    input  logic        hmastlock,
    output logic        hready,
    output logic [1:0]  hresp,
    output logic [31:0] hrdata
);

    localparam int AW = (MEM_WORDS > 1) ? $clog2(MEM_WORDS) : 1;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_WAIT = 2'd1;
    localparam logic [1:0] ST_ERR1 = 2'd2;
    localparam logic [1:0] ST_ERR2 = 2'd3;

    localparam logic [31:0] DEPTH     = 32'(MEM_WORDS);
    localparam logic [3:0]  WAIT_LAST = 4'((WAIT_STATES > 0) ? WAIT_STATES - 1 : 0);
    localparam bit          HAS_WAIT  = (WAIT_STATES > 0);

    logic [1:0]    state;
    logic [3:0]    wcnt;
    logic          done;      // IDLE state that is also a completion cycle

    logic [31:0]   a_addr;
    logic          a_write;
    logic [2:0]    a_size;
    logic [3:0]    a_master;  // kept for debug visibility only

    logic [31:0]   mem [MEM_WORDS];

    logic          accept;
    logic          illegal;
    logic          wr_en;
    logic [3:0]    lane_en;
    logic [AW-1:0] widx;

    // Inputs with no functional effect, folded so they are visibly consumed.
    logic unused_bits;
    assign unused_bits = ^{hburst, hmastlock, htrans[0], a_master, a_addr};

    // Output decode: ready in IDLE/ERR2, ERROR in both error states.
    always_comb begin
        hready = (state == ST_IDLE) || (state == ST_ERR2);
        hresp  = ((state == ST_ERR1) || (state == ST_ERR2)) ? 2'b01 : 2'b00;
        hrdata = (done && !a_write) ? mem[widx] : 32'h0;
    end

    // Address-phase acceptance and legality of the presented phase.
    always_comb begin
        accept  = hready && hsel && htrans[1];
        illegal = ({2'b00, haddr[31:2]} >= DEPTH) ||
                  (hsize > 3'd2) ||
                  ((hsize == 3'd2) && (haddr[1:0] != 2'b00)) ||
                  ((hsize == 3'd1) && haddr[0]);
    end

    // Byte-lane enables for the registered transfer (little-endian lanes).
    always_comb begin
        widx  = a_addr[AW+1:2];
        wr_en = done && a_write && !hreset;
        case (a_size)
            3'd0:    lane_en = 4'b0001 << a_addr[1:0];
            3'd1:    lane_en = a_addr[1] ? 4'b1100 : 4'b0011;
            default: lane_en = 4'b1111;
        endcase
    end

    // Transfer FSM: wait-state counting, error sequencing, completion flag.
    always_ff @(posedge hclk) begin
        if (hreset) begin
            state <= ST_IDLE;
            wcnt  <= 4'd0;
            done  <= 1'b0;
        end else begin
            case (state)
                ST_WAIT: begin
                    if (wcnt == WAIT_LAST) begin
                        state <= ST_IDLE;
                        wcnt  <= 4'd0;
                        done  <= 1'b1;
                    end else begin
                        wcnt <= wcnt + 4'd1;
                    end
                end
                ST_ERR1: begin
                    state <= ST_ERR2;
                    done  <= 1'b0;
                end
                default: begin
                    if (accept) begin
                        if (illegal) begin
                            state <= ST_ERR1;
                            done  <= 1'b0;
                        end else if (HAS_WAIT) begin
                            state <= ST_WAIT;
                            wcnt  <= 4'd0;
                            done  <= 1'b0;
                        end else begin
                            state <= ST_IDLE;
                            done  <= 1'b1;
                        end
                    end else begin
                        state <= ST_IDLE;
                        done  <= 1'b0;
                    end
                end
            endcase
        end
    end

    // Register the address-phase controls when a phase is taken.
    always_ff @(posedge hclk) begin
        if (accept) begin
            a_addr   <= haddr;
            a_write  <= hwrite;
            a_size   <= hsize;
            a_master <= hmaster;
        end
    end

    // Memory write at the edge ending a write completion; never reset.
    always_ff @(posedge hclk) begin
        if (wr_en) begin
            for (int b = 0; b < 4; b++) begin
                if (lane_en[b]) begin
                    mem[widx][8*b +: 8] <= hwdata[8*b +: 8];
                end
            end
        end
    end

endmodule

// File: tb/tb_ahb_slave_mem.sv
`timescale 1ns/1ps
module tb_ahb_slave_mem;

    localparam int MEM_WORDS = 256;

    // Clock / reset block
    logic hclk = 1'b0;
    always #5 hclk = ~hclk;

    int errors = 0;
    int checks = 0;

    task automatic check(input string name, input int inst,
                         input logic [31:0] got, input logic [31:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s inst=%0d t=%0t got=%h want=%h", name, inst, $time, got, want);
        end
    endtask

    task automatic timeout_fail(input string name, input int inst);
        checks++;
        errors++;
        $display("FAIL %s inst=%0d t=%0t got=timeout want=progress", name, inst, $time);
    endtask

    // Expected-cycle entry: [0] hready, [2:1] hresp, [3] read completes,
    // [4] write commits, [7:5] size, [39:8] address.
    function automatic logic [39:0] ent(input logic rdy, input logic [1:0] rsp,
                                        input logic rd, input logic wr,
                                        input logic [2:0] sz, input logic [31:0] a);
        return {a, sz, wr, rd, rsp, rdy};
    endfunction

    localparam logic [39:0] IDLE_ENT = 40'h1;

    for (genvar g = 0; g < 3; g++) begin : g_inst
        localparam int WS = (g == 0) ? 2 : ((g == 1) ? 0 : 3);

        logic        hreset, hsel, hwrite, hmastlock;
        logic [31:0] haddr, hwdata;
        logic [1:0]  htrans;
        logic [2:0]  hsize, hburst;
        logic [3:0]  hmaster;
        logic        hready;
        logic [1:0]  hresp;
        logic [31:0] hrdata;

        ahb_slave_mem #(.MEM_WORDS(MEM_WORDS), .WAIT_STATES(WS)) u_dut (
            .hclk(hclk), .hreset(hreset), .hsel(hsel), .haddr(haddr),
            .htrans(htrans), .hwrite(hwrite), .hsize(hsize), .hburst(hburst),
            .hwdata(hwdata), .hmaster(hmaster), .hmastlock(hmastlock),
            .hready(hready), .hresp(hresp), .hrdata(hrdata)
        );

        // Behavioural model: queue of expected future cycles plus a memory image.
        logic [39:0] exp_q[$];
        logic [31:0] model_mem [MEM_WORDS];
        bit          known [MEM_WORDS];
        bit          started = 1'b0;
        logic        done = 1'b0;
        logic        prev_ready = 1'b1;
        logic [31:0] bus_d = 32'h0;

        task automatic commit(input logic [31:0] a, input logic [2:0] sz, input logic [31:0] d);
            int w;
            w = int'(a[31:2]);
            for (int b = 0; b < 4; b++) begin
                bit en;
                en = (sz == 3'd2) ||
                     ((sz == 3'd1) && ((b / 2) == int'(a[1]))) ||
                     ((sz == 3'd0) && (b == int'(a[1:0])));
                if (en) model_mem[w][8*b +: 8] = d[8*b +: 8];
            end
            if (sz == 3'd2) known[w] = 1'b1;
        endtask

        task automatic push_xfer(input logic [31:0] a, input logic w, input logic [2:0] sz);
            bit bad;
            bad = (a[31:2] >= 30'(MEM_WORDS)) || (sz > 3'd2) ||
                  ((sz == 3'd2) && (a[1:0] != 2'b00)) || ((sz == 3'd1) && a[0]);
            if (bad) begin
                exp_q.push_back(ent(1'b0, 2'b01, 1'b0, 1'b0, sz, a));
                exp_q.push_back(ent(1'b1, 2'b01, 1'b0, 1'b0, sz, a));
            end else begin
                for (int i = 0; i < WS; i++) exp_q.push_back(ent(1'b0, 2'b00, 1'b0, 1'b0, sz, a));
                exp_q.push_back(ent(1'b1, 2'b00, !w, w, sz, a));
            end
        endtask

        // Model advance on each rising edge, from the inputs the bench drove.
        always @(posedge hclk) begin : model
            logic [39:0] cur;
            cur = IDLE_ENT;
            if (exp_q.size() > 0) cur = exp_q.pop_front();
            if (hreset) begin
                started = 1'b1;
                exp_q.delete();
            end else begin
                if (cur[4]) commit(cur[39:8], cur[7:5], hwdata);
                if (cur[0] && hsel && htrans[1]) push_xfer(haddr, hwrite, hsize);
            end
            if (exp_q.size() == 0) exp_q.push_back(IDLE_ENT);
        end

        // Scoreboard compare on the falling edge.
        always @(negedge hclk) begin : compare
            logic [39:0] h;
            logic [31:0] want_rd;
            if (started && exp_q.size() > 0) begin
                h = exp_q[0];
                check("hready", g, 32'(hready), 32'(h[0]));
                check("hresp", g, 32'(hresp), 32'(h[2:1]));
                if (!h[3] || known[h[17:10]]) begin
                    want_rd = h[3] ? model_mem[h[17:10]] : 32'h0;
                    check("hrdata", g, hrdata, want_rd);
                end
            end
        end

        // Driver tasks: the bus may change only after an edge that sampled hready=1.
        task automatic issue(input logic s, input logic [1:0] tr, input logic w,
                             input logic [31:0] a, input logic [2:0] sz, input logic [31:0] d);
            int n;
            logic r;
            n = 0;
            r = 1'b0;
            do begin
                @(negedge hclk);
                r = prev_ready;
                prev_ready = hready;
                n++;
            end while (!r && n < 64);
            if (!r) timeout_fail("bus_wait", g);
            hwdata    = bus_d;
            hsel      = s;
            htrans    = tr;
            hwrite    = w;
            haddr     = a;
            hsize     = sz;
            hburst    = 3'($urandom_range(0, 7));
            hmaster   = 4'($urandom_range(0, 15));
            hmastlock = 1'($urandom_range(0, 1));
            bus_d     = d;
        endtask

        task automatic wait_done(output logic [31:0] rd, output logic [1:0] rsp, output int waits);
            waits = 0;
            while (!hready && waits < 64) begin
                @(negedge hclk);
                prev_ready = hready;
                waits++;
            end
            if (!hready) timeout_fail("done_wait", g);
            rd  = hrdata;
            rsp = hresp;
        endtask

        task automatic xfer(input logic w, input logic [31:0] a, input logic [2:0] sz,
                            input logic [31:0] d, output logic [31:0] rd,
                            output logic [1:0] rsp, output int waits);
            issue(1'b1, 2'b10, w, a, sz, d);
            issue(1'b0, 2'b00, 1'b0, 32'h0, 3'd0, 32'h0);
            wait_done(rd, rsp, waits);
        endtask

        initial begin : driver
            logic [31:0] rd;
            logic [1:0]  rsp;
            int          waits;
            hreset = 1'b1; hsel = 1'b0; htrans = 2'b00; hwrite = 1'b0;
            haddr = 32'h0; hsize = 3'd0; hburst = 3'd0; hwdata = 32'h0;
            hmaster = 4'd0; hmastlock = 1'b0;
            repeat (3) @(negedge hclk);
            hreset = 1'b0;
            check("rst_hready", g, 32'(hready), 32'd1);
            check("rst_hresp", g, 32'(hresp), 32'd0);
            check("rst_hrdata", g, hrdata, 32'h0);
            prev_ready = hready;

            // Fill words 0..15 with back-to-back pipelined word writes.
            for (int w = 0; w < 16; w++) begin
                logic [31:0] d;
                d = (w == 0) ? 32'hCAFE_0000 : (w == 4) ? 32'h1122_3344 :
                    (w == 8) ? 32'h0BAD_F00D : $urandom;
                issue(1'b1, (w % 2 == 0) ? 2'b10 : 2'b11, 1'b1, 32'(w * 4), 3'd2, d);
            end

            if (g == 0) begin
                xfer(1'b1, 32'h10, 3'd2, 32'hDEAD_BEEF, rd, rsp, waits);
                check("wr_waits", g, 32'(waits), 32'd2);
                check("wr_resp", g, 32'(rsp), 32'd0);
                xfer(1'b0, 32'h10, 3'd2, 32'h0, rd, rsp, waits);
                check("rd_waits", g, 32'(waits), 32'd2);
                check("rd_data", g, rd, 32'hDEAD_BEEF);
            end else if (g == 1) begin
                xfer(1'b1, 32'h13, 3'd0, 32'hAA5A_3C0F, rd, rsp, waits);
                check("bwr_waits", g, 32'(waits), 32'd0);
                xfer(1'b0, 32'h10, 3'd2, 32'h0, rd, rsp, waits);
                check("brd_data", g, rd, 32'hAA22_3344);
                check("brd_waits", g, 32'(waits), 32'd0);
                xfer(1'b0, 32'h2, 3'd2, 32'h0, rd, rsp, waits);
                check("mis_waits", g, 32'(waits), 32'd1);
                check("mis_resp", g, 32'(rsp), 32'd1);
                check("mis_rdata", g, rd, 32'h0);
                xfer(1'b1, 32'(MEM_WORDS * 4), 3'd2, 32'h1234_5678, rd, rsp, waits);
                check("oor_waits", g, 32'(waits), 32'd1);
                check("oor_resp", g, 32'(rsp), 32'd1);
                issue(1'b1, 2'b01, 1'b1, 32'h0, 3'd2, 32'hFFFF_FFFF);
                issue(1'b0, 2'b10, 1'b1, 32'h0, 3'd2, 32'hFFFF_FFFF);
                issue(1'b0, 2'b00, 1'b0, 32'h0, 3'd0, 32'h0);
                xfer(1'b0, 32'h0, 3'd2, 32'h0, rd, rsp, waits);
                check("word0_kept", g, rd, 32'hCAFE_0000);
                issue(1'b1, 2'b10, 1'b1, 32'h14, 3'd2, 32'h7654_3210);
                issue(1'b1, 2'b10, 1'b0, 32'h14, 3'd2, 32'h0);
            end else begin
                issue(1'b1, 2'b10, 1'b1, 32'h20, 3'd2, 32'h5555_5555);
                issue(1'b0, 2'b00, 1'b0, 32'h0, 3'd0, 32'h0);
                @(negedge hclk);
                hreset = 1'b1;
                prev_ready = hready;
                @(negedge hclk);
                hreset = 1'b0;
                check("rstw_hready", g, 32'(hready), 32'd1);
                check("rstw_hresp", g, 32'(hresp), 32'd0);
                prev_ready = hready;
                xfer(1'b0, 32'h20, 3'd2, 32'h0, rd, rsp, waits);
                check("rstw_old", g, rd, 32'h0BAD_F00D);
                check("rstw_waits", g, 32'(waits), 32'd3);
            end

            // Randomized pipelined traffic, including illegal and idle phases.
            repeat (300) begin
                logic        s, w;
                logic [1:0]  tr;
                logic [2:0]  sz;
                logic [31:0] a;
                int          k;
                s  = ($urandom_range(0, 9) != 0);
                k  = $urandom_range(0, 7);
                tr = (k == 0) ? 2'b00 : (k == 1) ? 2'b01 : 2'(2 + (k % 2));
                w  = 1'($urandom_range(0, 1));
                sz = ($urandom_range(0, 9) == 0) ? 3'($urandom_range(3, 7)) : 3'($urandom_range(0, 2));
                k  = $urandom_range(0, 19);
                a  = (k == 0) ? 32'(MEM_WORDS * 4 + $urandom_range(0, 255)) :
                     (k == 1) ? $urandom : 32'($urandom_range(0, 63));
                issue(s, tr, w, a, sz, $urandom);
            end
            repeat (8) issue(1'b0, 2'b00, 1'b0, 32'h0, 3'd0, 32'h0);
            done = 1'b1;
        end
    end

    // Final report
    initial begin : report
        int n;
        n = 0;
        while (!(g_inst[0].done && g_inst[1].done && g_inst[2].done) && n < 50000) begin
            @(negedge hclk);
            n++;
        end
        if (n >= 50000) timeout_fail("run", -1);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/ahb_slave_mem.md
AHB_SLAVE_MEM -- requirements
Module: ahb_slave_mem

Interface
REQ-001 The block SHALL have one clock, hclk, and a synchronous active-high reset, hreset.
REQ-002 Parameter MEM_WORDS, default 256, SHALL set the memory depth in 32-bit words.
REQ-003 Parameter WAIT_STATES, default 2, range 0-15, SHALL set the number of hready-low cycles inserted per OKAY transfer.
REQ-004 The ports SHALL be, as name  direction  width  meaning:
- hclk  in  1  clock, rising edge.
- hreset  in  1  synchronous reset, active-high.
- hsel  in  1  slave select.
- haddr  in  32  byte address.
- htrans  in  2  transfer type: IDLE=0, BUSY=1, NONSEQ=2, SEQ=3.
- hwrite  in  1  1=write, 0=read.
- hsize  in  3  transfer size: 0=byte, 1=half, 2=word.
- hburst  in  3  burst type; accepted, not interpreted.
- hwdata  in  32  write data, valid in the data phase.
- hmaster  in  4  granted master ID; captured for debug only.
- hmastlock  in  1  locked transfer; ignored.
- hready  out  1  transfer-done / wait-state control.
- hresp  out  2  response: OKAY=0, ERROR=1; RETRY and SPLIT never driven.
- hrdata  out  32  read data.

Function
REQ-005 An address phase SHALL be accepted on a rising edge where hsel=1, hready=1 and htrans is NONSEQ or SEQ.
- On acceptance, haddr, hwrite, hsize and hmaster SHALL be registered.
REQ-006 When hsel=0, or htrans is IDLE or BUSY, while hready=1, the next cycle SHALL be hready=1 and hresp=OKAY with no memory access.
REQ-007 The FSM SHALL have four states: IDLE, WAIT, ERR1, ERR2.
REQ-008 The FSM transitions from an accepted phase SHALL be:
- any state -> ERR1 if the phase is illegal;
- any state -> WAIT if the phase is legal and WAIT_STATES>0;
- any state -> IDLE-with-completion if the phase is legal and WAIT_STATES=0.
REQ-009 An address phase SHALL be illegal if any of the following holds:
- haddr[31:2] >= MEM_WORDS;
- hsize > 2;
- hsize=2 and haddr[1:0] != 0;
- hsize=1 and haddr[0] != 0.
REQ-010 In WAIT the block SHALL drive hready=0 and hresp=OKAY for exactly WAIT_STATES cycles, counted by a 4-bit counter, then one completion cycle with hready=1 and hresp=OKAY.
REQ-011 On the completion cycle of a write, hwdata SHALL be committed at the rising edge ending that cycle, using little-endian byte lanes:
- byte write: lane haddr[1:0];
- half write: lanes {haddr[1],0} and {haddr[1],1};
- word write: all four lanes.
REQ-012 On the completion cycle of a read, hrdata SHALL present the full 32-bit word at haddr[31:2], whatever hsize is; at all other times hrdata SHALL be 0.
REQ-013 An illegal phase SHALL get a two-cycle response:
- ERR1: hready=0, hresp=ERROR;
- ERR2: hready=1, hresp=ERROR;
- no memory write occurs, and hrdata=0.
REQ-014 An address phase presented during ERR2 or a completion cycle SHALL be accepted (pipelined), so back-to-back zero-wait transfers complete one per cycle.
REQ-015 During hready=0 the block SHALL ignore haddr, htrans and the other address-phase inputs.
REQ-016 A read of a word written in the immediately preceding transfer SHALL return the new data (write-before-read ordering).
REQ-017 A write completion SHALL be blocked if an asserted hreset coincides with it.

Reset
REQ-018 While hreset=1 at a rising edge, the block SHALL enter IDLE and drive hready=1, hresp=OKAY and hrdata=0, with the wait counter cleared.
REQ-019 Reset asserted mid-transfer (WAIT, ERR1, ERR2) SHALL abort that transfer with no memory write and no ERROR completion.
REQ-020 Memory contents SHALL NOT be reset.

Verification
REQ-021 Word write then read, WAIT_STATES=2:
- stimulus: NONSEQ write 0x0000_0010 with 0xDEAD_BEEF, then NONSEQ read 0x10;
- required: each transfer has 2 cycles of hready=0 then 1 cycle of hready=1 with OKAY, and the read returns 0xDEAD_BEEF.
REQ-022 Byte write, WAIT_STATES=0:
- stimulus: byte write 0xAA at 0x13 over word 0x1122_3344;
- required: a read of 0x10 returns 0xAA22_3344, with single-cycle completions.
REQ-023 Misaligned word:
- stimulus: word read at 0x0000_0002;
- required: hready=0 with hresp=1 for one cycle, then hready=1 with hresp=1, and memory unchanged.
REQ-024 Out of range:
- stimulus: write at haddr=MEM_WORDS*4;
- required: two-cycle ERROR, and no write occurs at word 0 (no alias).
REQ-025 IDLE/BUSY and deselect:
- stimulus: htrans=BUSY with hsel=1, then hsel=0 with htrans=NONSEQ;
- required: hready=1 and hresp=OKAY throughout, and no access.
REQ-026 Reset mid-wait, WAIT_STATES=3:
- stimulus: assert hreset in the 2nd WAIT cycle of a write of 0x5555_5555 to 0x20;
- required: the next cycle has hready=1 and OKAY, and a later read of 0x20 returns the old value.
